// File: rtl/period_meter_if.sv
// period_meter_if: measurement input and result/handshake bundle for period_meter.
// master = the meter (drives results), slave = the consumer (drives the
// measured signal and the acknowledge).
interface period_meter_if #(
  parameter int CNT_W = 32
);
  logic             i_sig;
  logic             i_ack;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;
  logic             o_valid;
  logic             o_overrun;
  logic             o_timeout;

  modport master (
    input  i_sig, i_ack,
    output o_period, o_high, o_valid, o_overrun, o_timeout
  );

  modport slave (
    output i_sig, i_ack,
    input  o_period, o_high, o_valid, o_overrun, o_timeout
  );
endinterface

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow asynchronous input in
// i_clk cycles and hands each completed measurement over a valid/ack handshake.
// Optional macro PERIOD_METER_HIGH_EN: when defined the high-time counter is
// built; when undefined o_high is tied to zero and everything else is unchanged.
module period_meter #(
  parameter int          CNT_W   = 32,
  parameter logic [31:0] TIMEOUT = 32'd100000000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  period_meter_if.master bus
);

  localparam logic [0:0]       ST_IDLE    = 1'b0;
  localparam logic [0:0]       ST_MEAS    = 1'b1;
  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LP_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LP_ZERO    = {CNT_W{1'b0}};

  logic             r_s1;
  logic             r_s2;
  logic             r_d;
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_overrun;
  logic             r_timeout;

  logic w_edge;
  logic w_done;
  logic w_tmo;
  logic w_accept;

  // A rising edge of the synchronized input closes one period and opens the next.
  assign w_edge   = r_s2 & ~r_d;
  assign w_done   = (r_state == ST_MEAS) & w_edge;
  // The edge wins over the timeout when both land on the same cycle.
  assign w_tmo    = (r_state == ST_MEAS) & ~w_edge & (r_cnt == LP_TIMEOUT);
  assign w_accept = r_valid & bus.i_ack;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_d  <= 1'b0;
    end else begin
      r_s1 <= bus.i_sig;
      r_s2 <= r_s1;
      r_d  <= r_s2;
    end
  end

  // Measurement state: idle until the first edge, abandon on timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= w_edge ? ST_MEAS : ST_IDLE;
        ST_MEAS: r_state <= w_tmo ? ST_IDLE : ST_MEAS;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Period counter: restarts at 1 on every edge, saturates, cleared while idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= LP_ZERO;
    end else if (w_edge) begin
      r_cnt <= LP_ONE;
    end else if ((r_state == ST_IDLE) || w_tmo) begin
      r_cnt <= LP_ZERO;
    end else if (r_cnt != LP_CNT_MAX) begin
      r_cnt <= r_cnt + LP_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Latch the finished period when a measurement completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_period <= LP_ZERO;
    end else if (w_done) begin
      r_period <= r_cnt;
    end else begin
      r_period <= r_period;
    end
  end

  // Valid: set by a completion, cleared by an accepted ack (completion wins).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else if (w_done) begin
      r_valid <= 1'b1;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Sticky overrun: set when an unacknowledged result is overwritten; an ack
  // that coincides with a completion leaves it untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overrun <= 1'b0;
    end else if (w_done && r_valid && !bus.i_ack) begin
      r_overrun <= 1'b1;
    end else if (w_accept && !w_done) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  // Timeout level: raised when a measurement is abandoned, dropped by any edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timeout <= 1'b0;
    end else if (w_edge) begin
      r_timeout <= 1'b0;
    end else if (w_tmo) begin
      r_timeout <= 1'b1;
    end else begin
      r_timeout <= r_timeout;
    end
  end

`ifdef PERIOD_METER_HIGH_EN
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_high;

  // High-time counter: counts synchronized-high cycles within the current period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hcnt <= LP_ZERO;
    end else if (w_edge) begin
      r_hcnt <= LP_ONE;
    end else if ((r_state == ST_IDLE) || w_tmo) begin
      r_hcnt <= LP_ZERO;
    end else if (r_s2 && (r_hcnt != LP_CNT_MAX)) begin
      r_hcnt <= r_hcnt + LP_ONE;
    end else begin
      r_hcnt <= r_hcnt;
    end
  end

  // Latch the finished high time alongside the period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_high <= LP_ZERO;
    end else if (w_done) begin
      r_high <= r_hcnt;
    end else begin
      r_high <= r_high;
    end
  end

  assign bus.o_high = r_high;
`else
  assign bus.o_high = LP_ZERO;
`endif

  assign bus.o_period  = r_period;
  assign bus.o_valid   = r_valid;
  assign bus.o_overrun = r_overrun;
  assign bus.o_timeout = r_timeout;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: randomized and directed stimulus for period_meter with a
// queue-based scoreboard. Expected results come from the waveform the bench
// drives: each rising edge that follows an earlier one closes that earlier
// (period, high) segment.
module tb_period_meter;
  localparam int CNT_W = 16;
`ifdef PERIOD_METER_HIGH_EN
  localparam bit HIGH_EN = 1'b1;
`else
  localparam bit HIGH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  period_meter_if #(.CNT_W(CNT_W)) bus();

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(32'd1000)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;
  bit          man_ack = 1'b0;
  bit          have_edge = 1'b0;
  int          prev_p = 0;
  int          prev_h = 0;

  function automatic logic [31:0] pack(input int p, input int h);
    logic [15:0] hp;
    hp = HIGH_EN ? h[15:0] : 16'd0;
    return {p[15:0], hp};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full input period: high for h cycles, then low for p-h cycles.
  task automatic drive_period(input int p, input int h);
    if (have_edge && mon_en) exp_q.push_back(pack(prev_p, prev_h));
    have_edge = 1'b1;
    prev_p = p;
    prev_h = h;
    bus.i_sig = 1'b1;
    cycles(h);
    bus.i_sig = 1'b0;
    cycles(p - h);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_sig = 1'b0;
    cycles(1);
    rst = 1'b0;
    have_edge = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycles(1);
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: in auto mode pop/compare every presented result and ack it.
  initial begin
    logic [31:0] e;
    bus.i_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.o_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got result period %0d, expected none", bus.o_period);
          end else begin
            e = exp_q.pop_front();
            check("auto_period", 32'(bus.o_period), {16'd0, e[31:16]});
            check("auto_high", 32'(bus.o_high), {16'd0, e[15:0]});
            check("auto_overrun", 32'(bus.o_overrun), 32'd0);
          end
          bus.i_ack = 1'b1;
        end else begin
          bus.i_ack = 1'b0;
        end
      end else begin
        bus.i_ack = man_ack;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int p;
    int h;
    rst = 1'b1;
    bus.i_sig = 1'b0;
    cycles(3);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_period", 32'(bus.o_period), 32'd0);
    check("rst_high", 32'(bus.o_high), 32'd0);
    check("rst_overrun", 32'(bus.o_overrun), 32'd0);
    check("rst_timeout", 32'(bus.o_timeout), 32'd0);
    rst = 1'b0;

    // Square wave 20/10 then random periods, auto-acked.
    mon_en = 1'b1;
    cycles(3);
    for (int i = 0; i < 6; i++) drive_period(20, 10);
    for (int i = 0; i < 40; i++) begin
      p = int'($urandom_range(60, 2));
      h = int'($urandom_range(p - 1, 1));
      drive_period(p, h);
    end
    drive_period(20, 10);
    drain(200);

    // Single edge, then held high: no result, timeout raised.
    do_reset();
    cycles(5);
    bus.i_sig = 1'b1;
    cycles(900);
    check("tmo_not_yet", 32'(bus.o_timeout), 32'd0);
    cycles(200);
    check("tmo_set", 32'(bus.o_timeout), 32'd1);
    check("tmo_no_valid", 32'(bus.o_valid), 32'd0);
    bus.i_sig = 1'b0;
    cycles(10);
    // The abandoned segment never produces a result; restart with a fresh edge.
    bus.i_sig = 1'b1;
    cycles(3);
    check("tmo_cleared_by_edge", 32'(bus.o_timeout), 32'd0);
    cycles(7);
    bus.i_sig = 1'b0;
    cycles(10);
    have_edge = 1'b1;
    prev_p = 20;
    prev_h = 10;
    drive_period(20, 10);
    drive_period(20, 10);
    drain(50);

    // No ack: second result overruns; an ack then clears valid and overrun.
    mon_en = 1'b0;
    man_ack = 1'b0;
    do_reset();
    cycles(2);
    drive_period(30, 5);
    drive_period(30, 5);
    check("ovr_valid1", 32'(bus.o_valid), 32'd1);
    check("ovr_period1", 32'(bus.o_period), 32'd30);
    check("ovr_high1", 32'(bus.o_high), HIGH_EN ? 32'd5 : 32'd0);
    check("ovr_overrun1", 32'(bus.o_overrun), 32'd0);
    drive_period(30, 5);
    check("ovr_valid2", 32'(bus.o_valid), 32'd1);
    check("ovr_period2", 32'(bus.o_period), 32'd30);
    check("ovr_overrun2", 32'(bus.o_overrun), 32'd1);
    man_ack = 1'b1;
    cycles(1);
    man_ack = 1'b0;
    check("ovr_ack_valid", 32'(bus.o_valid), 32'd0);
    check("ovr_ack_overrun", 32'(bus.o_overrun), 32'd0);

    // Ack lands in the exact cycle a new result completes.
    do_reset();
    cycles(2);
    drive_period(24, 7);
    drive_period(20, 10);
    check("same_valid_pre", 32'(bus.o_valid), 32'd1);
    check("same_period_pre", 32'(bus.o_period), 32'd24);
    check("same_high_pre", 32'(bus.o_high), HIGH_EN ? 32'd7 : 32'd0);
    bus.i_sig = 1'b1;
    cycles(2);
    man_ack = 1'b1;
    cycles(1);
    man_ack = 1'b0;
    check("same_valid", 32'(bus.o_valid), 32'd1);
    check("same_period", 32'(bus.o_period), 32'd20);
    check("same_high", 32'(bus.o_high), HIGH_EN ? 32'd10 : 32'd0);
    check("same_overrun", 32'(bus.o_overrun), 32'd0);
    cycles(1);
    check("same_valid_hold", 32'(bus.o_valid), 32'd1);
    bus.i_sig = 1'b0;
    cycles(5);

    // Reset in the middle of a 50-cycle period.
    do_reset();
    cycles(2);
    drive_period(50, 25);
    drive_period(50, 25);
    check("mid_valid_pre", 32'(bus.o_valid), 32'd1);
    check("mid_period_pre", 32'(bus.o_period), 32'd50);
    bus.i_sig = 1'b1;
    cycles(25);
    bus.i_sig = 1'b0;
    cycles(5);
    rst = 1'b1;
    cycles(1);
    check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    check("mid_rst_period", 32'(bus.o_period), 32'd0);
    check("mid_rst_high", 32'(bus.o_high), 32'd0);
    check("mid_rst_overrun", 32'(bus.o_overrun), 32'd0);
    check("mid_rst_timeout", 32'(bus.o_timeout), 32'd0);
    rst = 1'b0;
    have_edge = 1'b0;
    cycles(20);
    drive_period(50, 25);
    check("mid_one_edge_no_valid", 32'(bus.o_valid), 32'd0);
    drive_period(50, 25);
    check("mid_valid_post", 32'(bus.o_valid), 32'd1);
    check("mid_period_post", 32'(bus.o_period), 32'd50);
    check("mid_high_post", 32'(bus.o_high), HIGH_EN ? 32'd25 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
